// File: rtl/pong_match_ctrl_pkg.sv
// Shared Pong constants: match states, UART command bytes, winner codes
// and a saturating score helper used by the match controller.
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } match_state_t;

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_PAUSE = 8'h50;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Adds one point but never goes past the winning score, so a score can
  // neither overshoot the limit nor wrap back to zero.
  function automatic logic [3:0] score_inc(input logic [3:0] score,
                                           input logic [3:0] limit);
    return (score < limit) ? score + 4'd1 : score;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_frame_tick.sv
// Frame tick generator: one-cycle pulse on each falling edge of VSync,
// i.e. at the end of every frame's active region.
module Pong_Frame_Tick
  import pong_match_ctrl_pkg::*;
(
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_VSync,
  output logic o_Tick
);

  logic vsync_q;

  // Keep last cycle's VSync; resetting it low means no tick right after reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= i_VSync;
    end
  end

  assign o_Tick = vsync_q & ~i_VSync;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve / play / point / pause / game-over,
// keeps both scores, picks the serve direction and declares the winner.
// All outputs come straight from registers.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 120
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_VSync,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic       o_Game_Active,
  output logic       o_Ball_Reset,
  output logic       o_Serve_Dir,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  // The frame counter must reach the longer of the two waits without wrapping.
  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN_Q      = 4'(WIN_SCORE);

  match_state_t     state_q, state_d;
  logic [3:0]       p1_q, p1_d;
  logic [3:0]       p2_q, p2_d;
  logic [1:0]       winner_q, winner_d;
  logic             serve_dir_q, serve_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             game_active_q, game_active_d;
  logic             ball_reset_q, ball_reset_d;
  logic             armed_q;

  logic             frame_tick;
  logic             cmd_valid;
  logic             cmd_start;
  logic             cmd_reset;
  logic             cmd_pause;
  logic [3:0]       p1_inc;
  logic [3:0]       p2_inc;

  Pong_Frame_Tick u_frame_tick (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_VSync (i_VSync),
    .o_Tick  (frame_tick)
  );

  // armed_q stays low for the first cycle after reset release, so a byte
  // arriving in that cycle is dropped rather than acted on.
  assign cmd_valid = i_RX_DV & armed_q;
  assign cmd_start = cmd_valid && (i_RX_Byte == CMD_START);
  assign cmd_reset = cmd_valid && (i_RX_Byte == CMD_RESET);
  assign cmd_pause = cmd_valid && (i_RX_Byte == CMD_PAUSE);

  assign p1_inc = score_inc(p1_q, WIN_Q);
  assign p2_inc = score_inc(p2_q, WIN_Q);

  // State, score and output registers; reset puts the match in IDLE with the ball held.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_IDLE;
      p1_q          <= 4'd0;
      p2_q          <= 4'd0;
      winner_q      <= WINNER_NONE;
      serve_dir_q   <= 1'b1;
      cnt_q         <= '0;
      game_active_q <= 1'b0;
      ball_reset_q  <= 1'b1;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      cnt_q         <= cnt_d;
      game_active_q <= game_active_d;
      ball_reset_q  <= ball_reset_d;
      armed_q       <= 1'b1;
    end
  end

  // Next-state and next-output logic; 'R' overrides everything, including a miss.
  always_comb begin
    state_d       = state_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    cnt_d         = cnt_q;
    game_active_d = 1'b0;
    ball_reset_d  = 1'b1;

    if (cmd_reset) begin
      state_d  = ST_IDLE;
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      winner_d = WINNER_NONE;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (cmd_start) begin
            state_d     = ST_SERVE;
            p1_d        = 4'd0;
            p2_d        = 4'd0;
            winner_d    = WINNER_NONE;
            serve_dir_d = 1'b1;
            cnt_d       = '0;
          end
        end

        ST_SERVE: begin
          if (frame_tick) begin
            if (cnt_q == SERVE_LAST) begin
              state_d = ST_PLAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_PLAY: begin
          if (i_P1_Miss && i_P2_Miss) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end else if (i_P1_Miss) begin
            p2_d        = p2_inc;
            serve_dir_d = 1'b0;
            cnt_d       = '0;
            if (p2_inc == WIN_Q) begin
              state_d  = ST_OVER;
              winner_d = WINNER_P2;
            end else begin
              state_d = ST_POINT;
            end
          end else if (i_P2_Miss) begin
            p1_d        = p1_inc;
            serve_dir_d = 1'b1;
            cnt_d       = '0;
            if (p1_inc == WIN_Q) begin
              state_d  = ST_OVER;
              winner_d = WINNER_P1;
            end else begin
              state_d = ST_POINT;
            end
          end else if (cmd_pause) begin
            state_d = ST_PAUSE;
          end
        end

        ST_POINT: begin
          if (frame_tick) begin
            if (cnt_q == POINT_LAST) begin
              state_d = ST_SERVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_PAUSE: begin
          if (cmd_pause) begin
            state_d = ST_PLAY;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    game_active_d = (state_d == ST_PLAY);
    ball_reset_d  = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                    (state_d == ST_POINT) || (state_d == ST_OVER);
  end

  assign o_Game_Active = game_active_q;
  assign o_Ball_Reset  = ball_reset_q;
  assign o_Serve_Dir   = serve_dir_q;
  assign o_P1_Score    = p1_q;
  assign o_P2_Score    = p2_q;
  assign o_Winner      = winner_q;
  assign o_State       = state_q;

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 9, points that win a match; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60, frame ticks the ball is held before launch.
REQ-003 Parameter POINT_FRAMES, default 120, frame ticks of pause after a scored point.
REQ-004 i_Clk  in  1  system clock, 25 MHz.
REQ-005 i_Rst_L  in  1  reset, asynchronous, active-low.
REQ-006 i_RX_DV  in  1  one-cycle pulse, i_RX_Byte valid.
REQ-007 i_RX_Byte  in  8  UART command byte.
REQ-008 i_VSync  in  1  VGA vertical sync, high during active rows.
REQ-009 i_P1_Miss, i_P2_Miss  in  1 each  one-cycle pulse, ball passed that player's paddle.
REQ-010 o_Game_Active  out  1  ball and paddles move.
REQ-011 o_Ball_Reset  out  1  hold ball at centre.
REQ-012 o_Serve_Dir  out  1  launch direction: 0 toward P1, 1 toward P2.
REQ-013 o_P1_Score, o_P2_Score  out  4 each  binary scores to the 7-segment converters.
REQ-014 o_Winner  out  2  00 none, 01 P1, 10 P2.
REQ-015 o_State  out  3  current state encoding, debug.

Function
REQ-016 Frame tick: one-cycle pulse on each 1->0 transition of i_VSync, detected using a registered copy of i_VSync; the first cycle after reset never produces a tick.
REQ-017 Commands are accepted only in the cycle where i_RX_DV=1: 0x53 'S' start, 0x52 'R' reset, 0x50 'P' pause toggle; all other bytes are ignored.
REQ-018 States: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5; every output is registered and reflects a transition one cycle after the triggering input.
REQ-019 IDLE: Ball_Reset=1, Game_Active=0; 'S' -> SERVE, scores cleared, Serve_Dir=1.
REQ-020 SERVE: Ball_Reset=1, Game_Active=0; frame counter cleared on entry and incremented per tick; after SERVE_FRAMES ticks -> PLAY.
REQ-021 PLAY: Game_Active=1, Ball_Reset=0; 'P' -> PAUSE.
REQ-022 PLAY, i_P1_Miss only: P2 score +1, Serve_Dir=0; i_P2_Miss only: P1 score +1, Serve_Dir=1.
REQ-023 PLAY, both miss pulses in the same cycle: no score change, Serve_Dir unchanged, -> SERVE (replay).
REQ-024 After an increment: if the new score equals WIN_SCORE -> OVER with Winner set; otherwise -> POINT.
REQ-025 POINT: Ball_Reset=1, Game_Active=0; after POINT_FRAMES ticks -> SERVE.
REQ-026 PAUSE: Game_Active=0, Ball_Reset=0 (ball frozen in place); 'P' -> PLAY; frame counter held.
REQ-027 OVER: Game_Active=0, Ball_Reset=1, scores frozen; 'S' -> SERVE with scores and Winner cleared, Serve_Dir=1.
REQ-028 'R' in any state -> IDLE next cycle; clears scores, Winner and frame counter; 'R' takes priority over a same-cycle miss pulse.
REQ-029 Miss pulses outside PLAY are ignored; a miss pulse coincident with 'P' in PLAY is scored and 'P' is dropped.
REQ-030 Scores never exceed WIN_SCORE and never wrap.
REQ-031 The frame counter is sized to hold max(SERVE_FRAMES, POINT_FRAMES) without wrap-around.

Reset
REQ-032 Asserting i_Rst_L=0 asynchronously forces IDLE, scores 0, Winner 00, Serve_Dir 1, Game_Active 0, Ball_Reset 1, frame counter 0, VSync history register 0.
REQ-033 Reset mid-match discards all state; no command is honoured in the first cycle after release.

Structure
REQ-034 State encodings, the command byte constants and the Winner encodings reside in a shared Pong constants include used by the Pong modules.
REQ-035 Frame-tick edge detection is a sub-module named Pong_Frame_Tick; all other logic stays in pong_match_ctrl.

Verification
REQ-036 Reset, then 'S' -> SERVE; 60 ticks -> PLAY; Game_Active rises exactly one cycle after the 60th tick.
REQ-037 In PLAY, i_P2_Miss pulse -> P1 score 1, Serve_Dir=1, POINT; after 120 ticks -> SERVE.
REQ-038 With WIN_SCORE=3, three i_P1_Miss pulses -> P2 score 3, Winner=10, OVER; a fourth miss pulse -> no change.
REQ-039 Both miss pulses in the same cycle in PLAY -> scores unchanged, SERVE; 'P' in PLAY -> PAUSE, counter frozen; second 'P' -> PLAY.
REQ-040 'R' during POINT with scores 2:1 -> IDLE, scores 0:0; i_Rst_L pulsed low mid-SERVE -> all outputs at reset values immediately, without waiting for a clock edge.
